// File: rtl/cnt1_pkg.sv
// Shared sizing helpers for the popcount accumulator.
//   num_granules : number of LUT granules covering one bus beat (last one zero-padded)
//   gcnt_width   : width of one granule popcount
//   psum_width   : width of one beat's popcount
//   cnt_width    : width of a full-vector popcount, holds the all-ones case
//   PIPE_LATENCY : register stages from input sampling to outputs
package cnt1_pkg;

    localparam int unsigned PIPE_LATENCY = 3;

    function automatic int unsigned num_granules(input int unsigned bus_width,
                                                 input int unsigned granule_width);
        return (bus_width + granule_width - 1) / granule_width;
    endfunction

    function automatic int unsigned gcnt_width(input int unsigned granule_width);
        return $clog2(granule_width + 1);
    endfunction

    function automatic int unsigned psum_width(input int unsigned bus_width);
        return $clog2(bus_width + 1);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned bus_width,
                                              input int unsigned sub_vector_no);
        return $clog2(bus_width * sub_vector_no + 1);
    endfunction

endpackage

// File: rtl/popcnt_granule.sv
// Combinational popcount of one granule slice.
//   slice_i : GRANULE_WIDTH input bits
//   cnt_o   : number of ones in slice_i
module popcnt_granule
    import cnt1_pkg::*;
#(
    parameter int unsigned GRANULE_WIDTH = 6,
    parameter int unsigned OUT_WIDTH     = gcnt_width(GRANULE_WIDTH)
) (
    input  logic [GRANULE_WIDTH-1:0] slice_i,
    output logic [OUT_WIDTH-1:0]     cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < int'(GRANULE_WIDTH); i++) begin
            cnt_o = cnt_o + OUT_WIDTH'(slice_i[i]);
        end
    end

endmodule

// File: rtl/cnt1_acc.sv
// Pipelined popcount accumulator. A vector arrives as SUB_VECTOR_NO beats; each beat is
// popcounted (granule LUTs -> adder) and the counts are summed over the vector. Each beat is
// passed through aligned with the count; a beat sampled at edge N is on the outputs from
// edge N+2, so three register stages (S1 granules, S2 beat sum, S3 accumulate/outputs).
//   clk, rstn     : clock, asynchronous active-low reset
//   i_Vector      : input beat
//   i_Valid       : beat valid (no backpressure, gaps allowed)
//   i_Flush       : abandon the partial vector and everything in flight
//   o_SubVector   : delayed accepted beat
//   o_SubValid    : o_SubVector valid
//   o_First/Last  : o_SubVector is the first/last beat of its vector
//   o_Cnt         : popcount of the last completed vector
//   o_CntValid    : strobe with the last beat of a vector
module cnt1_acc
    import cnt1_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = 128,
    parameter int unsigned SUB_VECTOR_NO = 2,
    parameter int unsigned GRANULE_WIDTH = 6,
    parameter int unsigned CNT_WIDTH     = cnt_width(BUS_WIDTH, SUB_VECTOR_NO)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [BUS_WIDTH-1:0] i_Vector,
    input  logic                 i_Valid,
    input  logic                 i_Flush,
    output logic [BUS_WIDTH-1:0] o_SubVector,
    output logic                 o_SubValid,
    output logic                 o_First,
    output logic                 o_Last,
    output logic [CNT_WIDTH-1:0] o_Cnt,
    output logic                 o_CntValid
);

    localparam int unsigned NumGran = num_granules(BUS_WIDTH, GRANULE_WIDTH);
    localparam int unsigned GcntW   = gcnt_width(GRANULE_WIDTH);
    localparam int unsigned PsumW   = psum_width(BUS_WIDTH);
    localparam int unsigned PadW    = NumGran * GRANULE_WIDTH;
    localparam int unsigned BeatW   = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(SUB_VECTOR_NO - 1);

    logic accept;
    assign accept = i_Valid & ~i_Flush;

    // Beat position within the current vector
    logic [BeatW-1:0] beat_q, beat_d;
    logic             beat_first, beat_last;

    always_comb begin
        beat_first = (beat_q == '0);
        beat_last  = (beat_q == LastBeat);
        beat_d     = beat_q;
        if (i_Flush) begin
            beat_d = '0;
        end else if (i_Valid) begin
            beat_d = beat_last ? '0 : beat_q + 1'b1;
        end
    end

    // Granule popcounts; zero-extension pads the final partial granule
    logic [PadW-1:0]  vec_pad;
    logic [GcntW-1:0] gcnt [NumGran];

    assign vec_pad = PadW'(i_Vector);

    for (genvar g = 0; g < int'(NumGran); g++) begin : g_gran
        popcnt_granule #(
            .GRANULE_WIDTH(GRANULE_WIDTH),
            .OUT_WIDTH    (GcntW)
        ) u_gran (
            .slice_i(vec_pad[g*GRANULE_WIDTH +: GRANULE_WIDTH]),
            .cnt_o  (gcnt[g])
        );
    end

    // S1
    logic                 s1_valid_q, s1_first_q, s1_last_q;
    logic [BUS_WIDTH-1:0] s1_data_q;
    logic [GcntW-1:0]     s1_gcnt_q [NumGran];

    // S2
    logic                 s2_valid_q, s2_first_q, s2_last_q;
    logic [BUS_WIDTH-1:0] s2_data_q;
    logic [PsumW-1:0]     s2_psum_q, psum;

    // S3
    logic                 s2_go;
    logic                 out_valid_q, out_first_q, out_last_q;
    logic [BUS_WIDTH-1:0] out_data_q;
    logic [CNT_WIDTH-1:0] acc_q, acc_d, cnt_q, cnt_d;

    always_comb begin
        psum = '0;
        for (int g = 0; g < int'(NumGran); g++) begin
            psum = psum + PsumW'(s1_gcnt_q[g]);
        end
    end

    // A flush kills everything still in S1/S2 so it never reaches the outputs
    assign s2_go = s2_valid_q & ~i_Flush;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (s2_go) begin
            acc_d = s2_first_q ? CNT_WIDTH'(s2_psum_q) : acc_q + CNT_WIDTH'(s2_psum_q);
            if (s2_last_q) begin
                cnt_d = acc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_data_q   <= '0;
            for (int g = 0; g < int'(NumGran); g++) begin
                s1_gcnt_q[g] <= '0;
            end
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_data_q   <= '0;
            s2_psum_q   <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            beat_q      <= beat_d;
            s1_valid_q  <= accept;
            s1_first_q  <= accept & beat_first;
            s1_last_q   <= accept & beat_last;
            if (accept) begin
                s1_data_q <= i_Vector;
                for (int g = 0; g < int'(NumGran); g++) begin
                    s1_gcnt_q[g] <= gcnt[g];
                end
            end
            s2_valid_q  <= s1_valid_q & ~i_Flush;
            s2_first_q  <= s1_first_q & ~i_Flush;
            s2_last_q   <= s1_last_q & ~i_Flush;
            if (s1_valid_q) begin
                s2_data_q <= s1_data_q;
                s2_psum_q <= psum;
            end
            out_valid_q <= s2_go;
            out_first_q <= s2_go & s2_first_q;
            out_last_q  <= s2_go & s2_last_q;
            if (s2_go) begin
                out_data_q <= s2_data_q;
            end
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_SubVector = out_data_q;
    assign o_SubValid  = out_valid_q;
    assign o_First     = out_first_q;
    assign o_Last      = out_last_q;
    assign o_Cnt       = cnt_q;
    assign o_CntValid  = out_valid_q & out_last_q;

endmodule

// File: tb/tb_cnt1_acc.sv
// Bench for cnt1_acc: directed test-plan steps plus random traffic, checked every cycle
// against a queue-based model of in-flight beats. DUT A uses defaults, DUT B uses
// BUS_WIDTH=64, SUB_VECTOR_NO=3, GRANULE_WIDTH=5; sel picks which one is driven and checked.
module tb_cnt1_acc;
    import cnt1_pkg::*;

    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] i_vector;
    logic         va, vb, i_flush;
    logic         sel;

    logic [127:0] a_vec;
    logic         a_valid, a_first, a_last, a_cntvalid;
    logic [8:0]   a_cnt;
    logic [63:0]  b_vec;
    logic         b_valid, b_first, b_last, b_cntvalid;
    logic [7:0]   b_cnt;

    always #5 clk = ~clk;

    cnt1_acc u_dut_a (
        .clk        (clk),
        .rstn       (rstn),
        .i_Vector   (i_vector),
        .i_Valid    (va),
        .i_Flush    (i_flush),
        .o_SubVector(a_vec),
        .o_SubValid (a_valid),
        .o_First    (a_first),
        .o_Last     (a_last),
        .o_Cnt      (a_cnt),
        .o_CntValid (a_cntvalid)
    );

    cnt1_acc #(
        .BUS_WIDTH    (64),
        .SUB_VECTOR_NO(3),
        .GRANULE_WIDTH(5)
    ) u_dut_b (
        .clk        (clk),
        .rstn       (rstn),
        .i_Vector   (i_vector[63:0]),
        .i_Valid    (vb),
        .i_Flush    (i_flush),
        .o_SubVector(b_vec),
        .o_SubValid (b_valid),
        .o_First    (b_first),
        .o_Last     (b_last),
        .o_Cnt      (b_cnt),
        .o_CntValid (b_cntvalid)
    );

    logic [127:0] obs_vec;
    logic         obs_valid, obs_first, obs_last, obs_cntvalid;
    logic [8:0]   obs_cnt;

    always_comb begin
        obs_vec      = sel ? {64'h0, b_vec} : a_vec;
        obs_valid    = sel ? b_valid : a_valid;
        obs_first    = sel ? b_first : a_first;
        obs_last     = sel ? b_last : a_last;
        obs_cntvalid = sel ? b_cntvalid : a_cntvalid;
        obs_cnt      = sel ? {1'b0, b_cnt} : a_cnt;
    end

    // Model: every accepted beat waits PIPE_LATENCY edges (counting its accept edge)
    typedef struct {
        logic [127:0] data;
        bit           first;
        bit           last;
        int           cnt;
        int           age;
    } beat_t;

    beat_t        q[$];
    int           m_svn;
    logic [127:0] m_mask;
    int           m_beat, m_acc, m_cnt;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           edge_n   = 0;
    int           strobe_edge;
    logic [8:0]   strobes[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_beat = 0;
        m_acc  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_edge(input bit v, input bit f, input logic [127:0] d);
        beat_t b;
        int    pc;
        if (q.size() > 0 && q[0].age == PIPE_LATENCY) void'(q.pop_front());
        if (f) begin
            q.delete();
            m_beat = 0;
        end else begin
            foreach (q[i]) q[i].age++;
        end
        if (v && !f) begin
            pc      = $countones(d & m_mask);
            b.data  = d & m_mask;
            b.first = (m_beat == 0);
            b.last  = (m_beat == m_svn - 1);
            m_acc   = b.first ? pc : m_acc + pc;
            b.cnt   = m_acc;
            b.age   = 1;
            q.push_back(b);
            m_beat  = b.last ? 0 : m_beat + 1;
        end
        if (q.size() > 0 && q[0].age == PIPE_LATENCY && q[0].last) m_cnt = q[0].cnt;
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (q.size() > 0) && (q[0].age == PIPE_LATENCY);
        chk("sub_valid", {127'h0, obs_valid}, {127'h0, ev});
        if (ev) begin
            chk("first", {127'h0, obs_first}, {127'h0, q[0].first});
            chk("last", {127'h0, obs_last}, {127'h0, q[0].last});
            chk("cnt_valid", {127'h0, obs_cntvalid}, {127'h0, q[0].last});
            chk("sub_vector", obs_vec, q[0].data);
        end else begin
            chk("first_idle", {127'h0, obs_first}, 128'h0);
            chk("last_idle", {127'h0, obs_last}, 128'h0);
            chk("cnt_valid_idle", {127'h0, obs_cntvalid}, 128'h0);
        end
        chk("cnt", {119'h0, obs_cnt}, 128'(m_cnt));
    endtask

    task automatic step(input bit v, input bit f, input logic [127:0] d);
        i_vector = v ? d : 'x;
        va       = v && !sel;
        vb       = v && sel;
        i_flush  = f;
        @(posedge clk);
        edge_n++;
        model_edge(v, f, d);
        #1;
        check_outputs();
        if (obs_cntvalid === 1'b1) begin
            strobes.push_back(obs_cnt);
            strobe_edge = edge_n;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 128'h0);
    endtask

    task automatic check_strobes(input string tag, input int n, input logic [8:0] last_cnt);
        chk({tag, "_strobes"}, 128'(strobes.size()), 128'(n));
        if (strobes.size() > 0) chk({tag, "_cnt"}, {119'h0, strobes[$]}, {119'h0, last_cnt});
        strobes.delete();
    endtask

    task automatic random_traffic(input int n);
        logic [127:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) d = '1;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, d);
        end
        idle(4);
        strobes.delete();
    endtask

    initial begin
        int e1;
        sel      = 1'b0;
        m_svn    = 2;
        m_mask   = '1;
        va       = 1'b0;
        vb       = 1'b0;
        i_flush  = 1'b0;
        i_vector = '0;
        rstn     = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("reset_sub_vector", a_vec, 128'h0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: contiguous beats, 32 + 64 ones
        step(1'b1, 1'b0, {32{4'h1}});
        step(1'b1, 1'b0, 128'hFFFFFFFF00000000FFFFFFFF00000000);
        e1 = edge_n;
        idle(4);
        check_strobes("t1", 1, 9'd96);
        chk("t1_strobe_edge", 128'(strobe_edge), 128'(e1 + PIPE_LATENCY - 1));

        // 2: full ones then zeros, back to back
        step(1'b1, 1'b0, '1);
        step(1'b1, 1'b0, '1);
        step(1'b1, 1'b0, 128'h0);
        step(1'b1, 1'b0, 128'h0);
        chk("t2_mid_strobes", 128'(strobes.size()), 128'd1);
        if (strobes.size() > 0) chk("t2_full_cnt", {119'h0, strobes[0]}, 128'd256);
        idle(4);
        check_strobes("t2", 2, 9'd0);

        // 3: gap mid-vector
        step(1'b1, 1'b0, '1);
        idle(5);
        step(1'b1, 1'b0, {32{4'hE}});
        idle(4);
        check_strobes("t3", 1, 9'd224);

        // 4: flush after first beat
        step(1'b1, 1'b0, {64{2'b01}});
        step(1'b0, 1'b1, 128'h0);
        step(1'b1, 1'b0, {16{8'hF0}});
        step(1'b1, 1'b0, {8{16'hE070}});
        idle(4);
        check_strobes("t4", 1, 9'd112);

        // 5: reset mid-vector
        step(1'b1, 1'b0, {8{16'h1234}});
        va = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_vec", a_vec, 128'h0);
        chk("t5_rst_valid", {127'h0, a_valid}, 128'h0);
        chk("t5_rst_first", {127'h0, a_first}, 128'h0);
        chk("t5_rst_last", {127'h0, a_last}, 128'h0);
        chk("t5_rst_cntvalid", {127'h0, a_cntvalid}, 128'h0);
        chk("t5_rst_cnt", {119'h0, a_cnt}, 128'h0);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        idle(3);
        step(1'b1, 1'b0, {8{16'h1234}});
        step(1'b1, 1'b0, {32{4'h1}});
        idle(4);
        check_strobes("t5", 1, 9'd72);

        random_traffic(400);

        // 6: narrow, three-beat configuration
        sel    = 1'b1;
        m_svn  = 3;
        m_mask = {64'h0, {64{1'b1}}};
        rstn   = 1'b0;
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        check_outputs();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '1);
        idle(4);
        check_strobes("t6", 1, 9'd192);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        end
        idle(4);
        chk("t6_b2b_strobes", 128'(strobes.size()), 128'd4);
        strobes.delete();

        random_traffic(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
